serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_ctrl_if.sv | 23 ++
 rtl/fa.sv | 11 +
 rtl/serial_adder_ctrl.sv | 100 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width: max(1, clog2(width)).
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/done handshake bundle between a requester and the serial adder controller.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start_valid, a, b, cin, done_ready,
    input  start_ready, done_valid, sum, cout, ovf
  );

  modport slave (
    input  start_valid, a, b, cin, done_ready,
    output start_ready, done_valid, sum, cout, ovf
  );
endinterface

// File: rtl/fa.sv
// 1-bit full-adder cell shared by the serial datapath.
module fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic c2
);
  assign sum = a ^ b ^ c;
  assign c2  = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first through one fa cell.
//
//   state | meaning
//   IDLE  | waiting for a start handshake; start_ready high
//   RUN   | one operand bit per clock through the fa cell
//   DONE  | result held on sum/cout/ovf until done_ready
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_adder_ctrl_if.slave bus
);
  import serial_adder_pkg::*;

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_c2;

  fa u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .c   (carry),
    .sum (fa_sum),
    .c2  (fa_c2)
  );

  // Written as shift-then-insert so WIDTH=1 needs no special case.
  always_comb begin
    sum_next            = sum_sh >> 1;
    sum_next[WIDTH-1]   = fa_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      a_sh            <= '0;
      b_sh            <= '0;
      sum_sh          <= '0;
      carry           <= 1'b0;
      cnt             <= '0;
      bus.start_ready <= 1'b1;
      bus.done_valid  <= 1'b0;
      bus.sum         <= '0;
      bus.cout        <= 1'b0;
      bus.ovf         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            a_sh            <= bus.a;
            b_sh            <= bus.b;
            carry           <= bus.cin;
            cnt             <= '0;
            sum_sh          <= '0;
            bus.start_ready <= 1'b0;
            state           <= RUN;
          end
        end
        RUN: begin
          sum_sh <= sum_next;
          carry  <= fa_c2;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CW'(1);
          // carry here is the carry into the MSB on the final bit
          if (cnt == LAST) begin
            bus.sum        <= sum_next;
            bus.cout       <= fa_c2;
            bus.ovf        <= carry ^ fa_c2;
            bus.done_valid <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          if (bus.done_ready) begin
            bus.done_valid  <= 1'b0;
            bus.start_ready <= 1'b1;
            state           <= IDLE;
          end
        end
        default: begin
          bus.done_valid  <= 1'b0;
          bus.start_ready <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1 builds).
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic a;
    logic b;
    logic cin;
    logic sum;
    logic cout;
    logic ovf;
  } vec1_t;

  // Run one WIDTH=8 operation with done_ready high; lat counts edges from accept to done_valid.
  task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        output logic [7:0] os, output logic oc, output logic oo, output int lat);
    int n;
    bus8.a = ia; bus8.b = ib; bus8.cin = ic;
    bus8.done_ready  = 1'b1;
    bus8.start_valid = 1'b1;
    n = 0;
    while (!bus8.start_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus8.start_valid = 1'b0;
    lat = 0;
    while (!bus8.done_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    os = bus8.sum; oc = bus8.cout; oo = bus8.ovf;
    @(posedge clk); #1;
  endtask

  task automatic do_op1(input logic ia, input logic ib, input logic ic,
                        output logic os, output logic oc, output logic oo, output int lat);
    int n;
    bus1.a = ia; bus1.b = ib; bus1.cin = ic;
    bus1.done_ready  = 1'b1;
    bus1.start_valid = 1'b1;
    n = 0;
    while (!bus1.start_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus1.start_valid = 1'b0;
    lat = 0;
    while (!bus1.done_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    os = bus1.sum; oc = bus1.cout; oo = bus1.ovf;
    @(posedge clk); #1;
  endtask

  // Back-to-back monitor state
  int cyc = 0;
  bit mon_en = 1'b0;
  int accepts[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus8.start_valid && bus8.start_ready) accepts.push_back(cyc);
      if (bus8.done_valid && bus8.done_ready) begin
        check("b2b_no_accept_on_done", {31'd0, bus8.start_ready}, 32'd0);
        check("b2b_sum", {24'd0, bus8.sum}, 32'h46);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    vec_t  vecs[8];
    vec1_t v1[3];
    logic [7:0] s8;
    logic s1, c, o;
    int lat;
    int dv_seen;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};

    v1[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    v1[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    v1[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    bus8.start_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.done_ready = 1'b1;
    bus1.start_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.done_ready = 1'b1;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start_ready", {31'd0, bus8.start_ready}, 32'd1);
    check("rst_done_valid",  {31'd0, bus8.done_valid}, 32'd0);
    check("rst_sum",         {24'd0, bus8.sum}, 32'd0);
    check("rst_cout",        {31'd0, bus8.cout}, 32'd0);
    check("rst_ovf",         {31'd0, bus8.ovf}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      do_op8(vecs[i].a, vecs[i].b, vecs[i].cin, s8, c, o, lat);
      check($sformatf("vec%0d_latency", i), lat, 32'd8);
      check($sformatf("vec%0d_sum", i),  {24'd0, s8}, {24'd0, vecs[i].sum});
      check($sformatf("vec%0d_cout", i), {31'd0, c},  {31'd0, vecs[i].cout});
      check($sformatf("vec%0d_ovf", i),  {31'd0, o},  {31'd0, vecs[i].ovf});
    end

    // Backpressure in DONE with start_valid pulsed on new operands
    bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.cin = 1'b0;
    bus8.done_ready = 1'b0;
    bus8.start_valid = 1'b1;
    @(posedge clk); #1;
    bus8.start_valid = 1'b0;
    lat = 0;
    while (!bus8.done_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    check("bp_latency", lat, 32'd8);
    for (int i = 0; i < 5; i++) begin
      bus8.start_valid = i[0] ? 1'b0 : 1'b1;
      bus8.a = 8'h11 + 8'(i); bus8.b = 8'h22; bus8.cin = 1'b1;
      @(posedge clk); #1;
      check($sformatf("bp%0d_done_valid", i), {31'd0, bus8.done_valid}, 32'd1);
      check($sformatf("bp%0d_start_ready", i), {31'd0, bus8.start_ready}, 32'd0);
      check($sformatf("bp%0d_result", i), {22'd0, bus8.sum, bus8.cout, bus8.ovf}, {22'd0, 8'h96, 1'b0, 1'b1});
    end
    bus8.start_valid = 1'b0;
    bus8.done_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_done_valid", {31'd0, bus8.done_valid}, 32'd0);
    check("bp_release_start_ready", {31'd0, bus8.start_ready}, 32'd1);
    check("bp_release_sum_held", {24'd0, bus8.sum}, 32'h96);

    // Reset on the 3rd RUN cycle discards the operation
    bus8.a = 8'h77; bus8.b = 8'h11; bus8.cin = 1'b0;
    bus8.start_valid = 1'b1;
    @(posedge clk); #1;
    bus8.start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_start_ready", {31'd0, bus8.start_ready}, 32'd1);
    check("mid_rst_done_valid",  {31'd0, bus8.done_valid}, 32'd0);
    check("mid_rst_sum",         {24'd0, bus8.sum}, 32'd0);
    dv_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus8.done_valid) dv_seen++;
    end
    check("mid_rst_no_done_pulse", dv_seen, 32'd0);
    do_op8(8'h01, 8'h02, 1'b0, s8, c, o, lat);
    check("post_rst_sum", {24'd0, s8}, 32'h03);
    check("post_rst_latency", lat, 32'd8);

    // Back-to-back: start_valid held high, done_ready high
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0;
    bus8.done_ready = 1'b1;
    bus8.start_valid = 1'b1;
    mon_en = 1'b1;
    repeat (45) @(posedge clk);
    #1;
    mon_en = 1'b0;
    bus8.start_valid = 1'b0;
    check("b2b_accept_count_ge4", {31'd0, accepts.size() >= 4}, 32'd1);
    for (int i = 1; i < accepts.size(); i++)
      check($sformatf("b2b_spacing%0d", i), accepts[i] - accepts[i-1], 32'd10);
    repeat (12) @(posedge clk);
    #1;

    // WIDTH=1 build
    for (int i = 0; i < 3; i++) begin
      do_op1(v1[i].a, v1[i].b, v1[i].cin, s1, c, o, lat);
      check($sformatf("w1_vec%0d_latency", i), lat, 32'd1);
      check($sformatf("w1_vec%0d_sum", i),  {31'd0, s1}, {31'd0, v1[i].sum});
      check($sformatf("w1_vec%0d_cout", i), {31'd0, c},  {31'd0, v1[i].cout});
      check($sformatf("w1_vec%0d_ovf", i),  {31'd0, o},  {31'd0, v1[i].ovf});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
